// File: rtl/seqdet_pkg.sv
// Shared definitions for the serial pattern detector: width helper,
// pattern-length clamp and the overlap-mode encoding.
package seqdet_pkg;

  typedef enum logic {
    SEQ_NONOVL = 1'b0,
    SEQ_OVL    = 1'b1
  } seq_ovl_e;

  // Bits needed to hold a length value in the range 0..pat_w.
  function automatic int calc_len_w(input int pat_w);
    int w;
    w = 1;
    while ((1 << w) < (pat_w + 1)) begin
      w = w + 1;
    end
    return w;
  endfunction

  // A length of zero or one beyond the window cannot be matched, so it
  // falls back to the full window.
  function automatic int clamp_len(input int len, input int pat_w);
    if ((len == 0) || (len > pat_w)) begin
      return pat_w;
    end else begin
      return len;
    end
  endfunction

  // True when clamp_len would have to alter the requested length.
  function automatic logic len_is_illegal(input int len, input int pat_w);
    if ((len == 0) || (len > pat_w)) begin
      return 1'b1;
    end else begin
      return 1'b0;
    end
  endfunction

endpackage

// File: rtl/seqdet_window_cmp.sv
// Combinational window compare: the lowest len bits of the history must
// equal the lowest len bits of the pattern and enough history must exist.
module seqdet_window_cmp
  import seqdet_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4
) (
  input  logic [PAT_W-1:0] hist,
  input  logic [PAT_W-1:0] pat,
  input  logic [LEN_W-1:0] len,
  input  logic [LEN_W-1:0] fill,
  output logic             hit
);

  logic [PAT_W-1:0] mask_s;

  // Build a mask with ones in the lowest len bit positions.
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < PAT_W; i++) begin
      if (i < int'(len)) begin
        mask_s[i] = 1'b1;
      end else begin
        mask_s[i] = 1'b0;
      end
    end
  end

  // Hit needs a full window of history and no differing bit under the mask.
  always_comb begin
    if ((fill >= len) && (((hist ^ pat) & mask_s) == '0)) begin
      hit = 1'b1;
    end else begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/pattern_seq_detector.sv
// Run-time configurable Moore serial pattern detector with overlap control,
// saturating match counter and a sticky flag for clamped length loads.
module pattern_seq_detector
  import seqdet_pkg::*;
#(
  parameter int               PAT_W   = 8,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] RST_PAT = 8'b0000_1011,
  parameter int               RST_LEN = 4,
  localparam int              LEN_W   = calc_len_w(PAT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             din,
  input  logic             cfg_load,
  input  logic [PAT_W-1:0] cfg_pat,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_ovl,
  input  logic             clr,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cfg_err
);

  localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] LEN_RST  = LEN_W'(clamp_len(RST_LEN, PAT_W));

  logic [PAT_W-1:0] hist_r;
  logic [LEN_W-1:0] fill_r;
  logic [PAT_W-1:0] pat_r;
  logic [LEN_W-1:0] len_r;
  seq_ovl_e         ovl_r;
  logic             match_r;
  logic [CNT_W-1:0] match_cnt_r;
  logic             cfg_err_r;

  logic             accept_s;
  logic [PAT_W-1:0] hist_next_s;
  logic [LEN_W-1:0] fill_inc_s;
  logic             cmp_hit_s;
  logic             hit_s;
  logic [LEN_W-1:0] cfg_len_clamped_s;
  logic             cfg_len_bad_s;

  // Post-shift window and saturating fill for the bit being offered.
  always_comb begin
    accept_s    = en & ~cfg_load & ~clr;
    hist_next_s = {hist_r[PAT_W-2:0], din};
    if (fill_r == FILL_MAX) begin
      fill_inc_s = fill_r;
    end else begin
      fill_inc_s = fill_r + LEN_W'(1);
    end
  end

  // Clamp the requested length and flag it when it had to be changed.
  always_comb begin
    cfg_len_clamped_s = LEN_W'(clamp_len(int'(cfg_len), PAT_W));
    cfg_len_bad_s     = len_is_illegal(int'(cfg_len), PAT_W);
  end

  seqdet_window_cmp #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_cmp (
    .hist (hist_next_s),
    .pat  (pat_r),
    .len  (len_r),
    .fill (fill_inc_s),
    .hit  (cmp_hit_s)
  );

  // A hit only counts for a bit that is actually accepted.
  always_comb begin
    if (accept_s) begin
      hit_s = cmp_hit_s;
    end else begin
      hit_s = 1'b0;
    end
  end

  // History shift register and fill count; non-overlap restarts after a hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r <= '0;
      fill_r <= '0;
    end else if (clr || cfg_load) begin
      hist_r <= '0;
      fill_r <= '0;
    end else if (accept_s) begin
      hist_r <= hist_next_s;
      if (hit_s && (ovl_r == SEQ_NONOVL)) begin
        fill_r <= '0;
      end else begin
        fill_r <= fill_inc_s;
      end
    end else begin
      hist_r <= hist_r;
      fill_r <= fill_r;
    end
  end

  // Active configuration, captured only on a load cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_r     <= RST_PAT;
      len_r     <= LEN_RST;
      ovl_r     <= SEQ_OVL;
      cfg_err_r <= 1'b0;
    end else if (cfg_load) begin
      pat_r     <= cfg_pat;
      len_r     <= cfg_len_clamped_s;
      ovl_r     <= seq_ovl_e'(cfg_ovl);
      cfg_err_r <= cfg_len_bad_s;
    end else begin
      pat_r     <= pat_r;
      len_r     <= len_r;
      ovl_r     <= ovl_r;
      cfg_err_r <= cfg_err_r;
    end
  end

  // One-cycle match pulse and saturating detection counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_r     <= 1'b0;
      match_cnt_r <= '0;
    end else if (clr) begin
      match_r     <= 1'b0;
      match_cnt_r <= '0;
    end else if (cfg_load) begin
      match_r     <= 1'b0;
      match_cnt_r <= match_cnt_r;
    end else begin
      match_r <= hit_s;
      if (hit_s && (match_cnt_r != {CNT_W{1'b1}})) begin
        match_cnt_r <= match_cnt_r + CNT_W'(1);
      end else begin
        match_cnt_r <= match_cnt_r;
      end
    end
  end

  assign match     = match_r;
  assign match_cnt = match_cnt_r;
  assign cfg_err   = cfg_err_r;

endmodule
